// File: rtl/aes_dec_round_scheduler.sv
// Iterative AES-128 decryption controller: sequences an external inverse-round
// datapath and an external key-expansion step, holding all 11 round keys locally.
module aes_dec_round_scheduler #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          KEY_LOAD,
  input  logic [0:KW-1] CIPHER_KEY,
  output logic          KEY_VALID,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [0:KW-1] ENCRYPTED_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [0:KW-1] ORIGINAL_DECRYPTED_DATA,
  output logic          BUSY,
  output logic [0:KW-1] KS_PREV_KEY,
  output logic [0:31]   KS_RCON,
  input  logic [0:KW-1] KS_NEW_KEY,
  output logic [0:KW-1] RD_STATE,
  output logic [0:KW-1] RD_KEY,
  output logic          RD_FINAL,
  input  logic [0:KW-1] RD_RESULT
);

  localparam int unsigned CW = 4;
  localparam int unsigned RCW = 32;

  if (NR != 10 || KW != 128) begin : g_cfg_check
    $error("aes_dec_round_scheduler supports only AES-128 (NR=10, KW=128)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_READY,
    S_ROUND,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] kidx;
  logic [CW-1:0] rnd;
  logic [0:KW-1] data_q;
  logic [0:KW-1] rk [0:NR];
  logic          key_start_c;

  // Key load is honoured in IDLE, or in READY only when no block is offered.
  assign key_start_c = !RST && KEY_LOAD &&
                       ((state == S_IDLE) || ((state == S_READY) && !IN_VALID));

  function automatic logic [7:0] rcon_byte(input logic [CW-1:0] i);
    logic [7:0] v;
    v = 8'h00;
    case (i)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Round key store; never reset, validity is tracked by KEY_VALID.
  always_ff @(posedge CLK) begin
    if (key_start_c) begin
      rk[0] <= CIPHER_KEY;
    end else if (!RST && state == S_KEXP) begin
      rk[kidx] <= KS_NEW_KEY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                   <= S_IDLE;
      kidx                    <= '0;
      rnd                     <= '0;
      data_q                  <= '0;
      ORIGINAL_DECRYPTED_DATA <= '0;
      KEY_VALID               <= 1'b0;
      IN_READY                <= 1'b0;
      OUT_VALID               <= 1'b0;
      BUSY                    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_start_c) begin
            kidx      <= CW'(1);
            KEY_VALID <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_KEXP;
          end
        end
        S_KEXP: begin
          if (kidx == CW'(NR)) begin
            KEY_VALID <= 1'b1;
            IN_READY  <= 1'b1;
            BUSY      <= 1'b0;
            state     <= S_READY;
          end else begin
            kidx <= kidx + CW'(1);
          end
        end
        S_READY: begin
          if (IN_VALID) begin
            data_q   <= ENCRYPTED_DATA ^ rk[NR];
            rnd      <= CW'(NR - 1);
            IN_READY <= 1'b0;
            BUSY     <= 1'b1;
            state    <= S_ROUND;
          end else if (key_start_c) begin
            kidx      <= CW'(1);
            KEY_VALID <= 1'b0;
            IN_READY  <= 1'b0;
            BUSY      <= 1'b1;
            state     <= S_KEXP;
          end
        end
        S_ROUND: begin
          data_q <= RD_RESULT;
          if (rnd == '0) begin
            ORIGINAL_DECRYPTED_DATA <= RD_RESULT;
            OUT_VALID               <= 1'b1;
            BUSY                    <= 1'b0;
            state                   <= S_DONE;
          end else begin
            rnd <= rnd - CW'(1);
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shared-datapath operands; forced to zero when the owning phase is inactive.
  always_comb begin
    KS_PREV_KEY = '0;
    KS_RCON     = '0;
    RD_STATE    = '0;
    RD_KEY      = '0;
    RD_FINAL    = 1'b0;
    if (state == S_KEXP) begin
      KS_PREV_KEY = rk[kidx - CW'(1)];
      KS_RCON     = {rcon_byte(kidx), (RCW - 8)'(0)};
    end
    if (state == S_ROUND) begin
      RD_STATE = data_q;
      RD_KEY   = rk[rnd];
      RD_FINAL = (rnd == '0);
    end
  end

endmodule
